// File: rtl/setup_buf_fill_engine.sv
// Fills a buffer with a ZERO / LINE_IDX / INCR pattern: one write request, then size/line_bytes data lines, then a completion.
// Latency: 1 cycle per step (cmd->req, req->data, last line->done); every *_val comes straight from FSM state, so *_rdy never feeds back into it.
module setup_buf_fill_engine #(
    parameter int DATA_W    = 512,
    parameter int WORD_W    = 32,
    parameter int FLOWID_W  = 8,
    parameter int MAX_PTR_W = 16,
    parameter int CONN_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_val,
    output logic                  cmd_rdy,
    input  logic [FLOWID_W-1:0]   cmd_flowid,
    input  logic [4:0]            cmd_log2_size,
    input  logic [1:0]            cmd_mode,
    output logic                  wr_req_val,
    input  logic                  wr_req_rdy,
    output logic [FLOWID_W-1:0]   wr_req_flowid,
    output logic [MAX_PTR_W-1:0]  wr_req_offset,
    output logic [MAX_PTR_W:0]    wr_req_size,
    output logic                  wr_data_val,
    input  logic                  wr_data_rdy,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  wr_data_last,
    output logic                  done_val,
    input  logic                  done_rdy,
    output logic [FLOWID_W-1:0]   done_flowid,
    input  logic [CONN_W-1:0]     cfg_num_conns,
    input  logic                  clear_conns,
    output logic [CONN_W-1:0]     conns_done,
    output logic                  all_conns_done
);
    localparam int LINE_L2 = $clog2(DATA_W / 8);
    localparam int WPL     = DATA_W / WORD_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [MAX_PTR_W:0]   SIZE_ONE = 1;
    localparam logic [MAX_PTR_W-1:0] LINE_ONE = 1;
    localparam logic [CONN_W-1:0]    CONN_ONE = 1;

    logic [1:0]            r_state;
    logic [FLOWID_W-1:0]   r_flowid;
    logic [1:0]            r_mode;
    logic [MAX_PTR_W:0]    r_size;
    logic [MAX_PTR_W-1:0]  r_last;
    logic [MAX_PTR_W-1:0]  r_line;
    logic [CONN_W-1:0]     r_conns;

    logic [4:0]            w_eff_l2;
    logic [MAX_PTR_W:0]    w_size;
    logic [MAX_PTR_W-1:0]  w_last_line;
    logic [DATA_W-1:0]     w_data;
    logic [WORD_W-1:0]     w_word;
    logic                  w_done_hs;

    // Never smaller than one line, never larger than the addressable buffer.
    always_comb begin
        w_eff_l2 = cmd_log2_size;
        if (cmd_log2_size < 5'(LINE_L2))
            w_eff_l2 = 5'(LINE_L2);
        else if (cmd_log2_size > 5'(MAX_PTR_W))
            w_eff_l2 = 5'(MAX_PTR_W);
    end

    assign w_size      = SIZE_ONE << w_eff_l2;
    assign w_last_line = MAX_PTR_W'((w_size >> LINE_L2) - SIZE_ONE);
    assign w_done_hs   = (r_state == S_DONE) && done_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_flowid <= '0;
            r_mode   <= '0;
            r_size   <= '0;
            r_last   <= '0;
            r_line   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_val) begin
                    r_flowid <= cmd_flowid;
                    r_mode   <= cmd_mode;
                    r_size   <= w_size;
                    r_last   <= w_last_line;
                    r_state  <= S_REQ;
                end
                S_REQ: if (wr_req_rdy) begin
                    r_line  <= '0;
                    r_state <= S_DATA;
                end
                S_DATA: if (wr_data_rdy) begin
                    if (r_line == r_last)
                        r_state <= S_DONE;
                    else
                        r_line <= r_line + LINE_ONE;
                end
                S_DONE: if (done_rdy)
                    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Clear wins over a coincident completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_conns <= '0;
        else if (clear_conns)
            r_conns <= '0;
        else if (w_done_hs && (r_conns != '1))
            r_conns <= r_conns + CONN_ONE;
    end

    always_comb begin
        w_data = '0;
        w_word = '0;
        for (int k = 0; k < WPL; k++) begin
            case (r_mode)
                2'd1:    w_word = WORD_W'(r_line);
                2'd2:    w_word = WORD_W'(r_line) * WORD_W'(WPL) + WORD_W'(k);
                default: w_word = '0;
            endcase
            w_data[k*WORD_W +: WORD_W] = w_word;
        end
    end

    assign cmd_rdy        = (r_state == S_IDLE);
    assign wr_req_val     = (r_state == S_REQ);
    assign wr_req_flowid  = r_flowid;
    assign wr_req_offset  = '0;
    assign wr_req_size    = r_size;
    assign wr_data_val    = (r_state == S_DATA);
    assign wr_data        = (r_state == S_DATA) ? w_data : '0;
    assign wr_data_last   = (r_state == S_DATA) && (r_line == r_last);
    assign done_val       = (r_state == S_DONE);
    assign done_flowid    = r_flowid;
    assign conns_done     = r_conns;
    assign all_conns_done = (r_conns == cfg_num_conns) && (cfg_num_conns != '0);
endmodule

// File: tb/tb_setup_buf_fill_engine.sv
// Bench for setup_buf_fill_engine: table of directed fills, hand-built corner sequences, then random fills vs a pattern model.
module tb_setup_buf_fill_engine;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_val = 1'b0;
    logic            cmd_rdy;
    logic [7:0]      cmd_flowid = '0;
    logic [4:0]      cmd_log2_size = '0;
    logic [1:0]      cmd_mode = '0;
    logic            wr_req_val;
    logic            wr_req_rdy = 1'b0;
    logic [7:0]      wr_req_flowid;
    logic [15:0]     wr_req_offset;
    logic [16:0]     wr_req_size;
    logic            wr_data_val;
    logic            wr_data_rdy = 1'b0;
    logic [DW-1:0]   wr_data;
    logic            wr_data_last;
    logic            done_val;
    logic            done_rdy = 1'b0;
    logic [7:0]      done_flowid;
    logic [15:0]     cfg_num_conns = 16'd3;
    logic            clear_conns = 1'b0;
    logic [15:0]     conns_done;
    logic            all_conns_done;

    int n_checks = 0;
    int n_errors = 0;
    int exp_conns = 0;

    setup_buf_fill_engine dut (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_flowid(cmd_flowid),
        .cmd_log2_size(cmd_log2_size), .cmd_mode(cmd_mode),
        .wr_req_val(wr_req_val), .wr_req_rdy(wr_req_rdy), .wr_req_flowid(wr_req_flowid),
        .wr_req_offset(wr_req_offset), .wr_req_size(wr_req_size),
        .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy), .wr_data(wr_data),
        .wr_data_last(wr_data_last),
        .done_val(done_val), .done_rdy(done_rdy), .done_flowid(done_flowid),
        .cfg_num_conns(cfg_num_conns), .clear_conns(clear_conns),
        .conns_done(conns_done), .all_conns_done(all_conns_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fid;
        int l2;
        int mode;
        int exp_size;
        int exp_lines;
        int pat;   // 0 always ready, 1 toggle 1/0, 2 random
        int hold;  // keep cmd_val high through the fill
    } vec_t;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line n, word k: ZERO/reserved -> 0, LINE_IDX -> n, INCR -> n*16+k.
    function automatic logic [DW-1:0] exp_line(int mode, int n);
        logic [DW-1:0] v = '0;
        for (int k = 0; k < 16; k++) begin
            int w = (mode == 1) ? n : (mode == 2) ? n * 16 + k : 0;
            v[k*32 +: 32] = 32'(w);
        end
        return v;
    endfunction

    task automatic chk_quiet(string tag);
        chk({tag, "_cmd_rdy"}, DW'(cmd_rdy), DW'(1));
        chk({tag, "_req_val"}, DW'(wr_req_val), DW'(0));
        chk({tag, "_req_size"}, DW'(wr_req_size), DW'(0));
        chk({tag, "_data_val"}, DW'(wr_data_val), DW'(0));
        chk({tag, "_data"}, wr_data, DW'(0));
        chk({tag, "_last"}, DW'(wr_data_last), DW'(0));
        chk({tag, "_done_val"}, DW'(done_val), DW'(0));
        chk({tag, "_done_fid"}, DW'(done_flowid), DW'(0));
        chk({tag, "_conns"}, DW'(conns_done), DW'(0));
    endtask

    // Called and returns at a negedge. abort_line >= 0 asserts rst on that line.
    task automatic run_fill(int fid, int l2, int mode, int exp_size, int exp_lines,
                            int pat, int hold, int clr, int abort_line);
        int n = 0;
        int cyc = 0;
        int d;
        logic rdy;
        chk("cmd_rdy_idle", DW'(cmd_rdy), DW'(1));
        cmd_flowid = 8'(fid); cmd_log2_size = 5'(l2); cmd_mode = 2'(mode); cmd_val = 1'b1;
        @(negedge clk);
        if (hold == 0) cmd_val = 1'b0;
        chk("req_val", DW'(wr_req_val), DW'(1));
        chk("req_size", DW'(wr_req_size), DW'(exp_size));
        chk("req_offset", DW'(wr_req_offset), DW'(0));
        chk("req_fid", DW'(wr_req_flowid), DW'(fid));
        chk("cmd_rdy_busy", DW'(cmd_rdy), DW'(0));
        d = (pat == 2) ? $urandom_range(0, 2) : 0;
        for (int j = 0; j < d; j++) begin
            @(negedge clk);
            chk("req_val_hold", DW'(wr_req_val), DW'(1));
        end
        wr_req_rdy = 1'b1;
        @(negedge clk);
        wr_req_rdy = 1'b0;
        while (n < exp_lines && cyc < exp_lines * 4 + 20) begin
            chk("data_val", DW'(wr_data_val), DW'(1));
            chk($sformatf("data_line%0d", n), wr_data, exp_line(mode, n));
            chk("data_last", DW'(wr_data_last), DW'(n == exp_lines - 1));
            if (n == abort_line) begin
                rst = 1'b1;
                #1;
                chk_quiet("abort");
                exp_conns = 0;
                wr_data_rdy = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            wr_data_rdy = rdy;
            @(negedge clk);
            if (rdy) n++;
            cyc++;
        end
        wr_data_rdy = 1'b0;
        if (n < exp_lines) begin
            n_checks++; n_errors++;
            $display("FAIL data_timeout: got %0d lines expected %0d", n, exp_lines);
        end
        chk("done_val", DW'(done_val), DW'(1));
        chk("done_fid", DW'(done_flowid), DW'(fid));
        chk("cmd_rdy_done", DW'(cmd_rdy), DW'(0));
        done_rdy = 1'b1;
        clear_conns = 1'(clr);
        @(negedge clk);
        done_rdy = 1'b0;
        clear_conns = 1'b0;
        if (clr != 0) exp_conns = 0;
        else if (exp_conns != 65535) exp_conns++;
        chk("conns_done", DW'(conns_done), DW'(exp_conns));
        chk("all_conns", DW'(all_conns_done),
            DW'(exp_conns == int'(cfg_num_conns) && cfg_num_conns != 0));
        chk("cmd_rdy_after", DW'(cmd_rdy), DW'(1));
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{fid: 5, l2: 8,  mode: 1, exp_size: 256,   exp_lines: 4,    pat: 0, hold: 0};
        tbl[1] = '{fid: 9, l2: 7,  mode: 2, exp_size: 128,   exp_lines: 2,    pat: 1, hold: 0};
        tbl[2] = '{fid: 3, l2: 2,  mode: 0, exp_size: 64,    exp_lines: 1,    pat: 0, hold: 0};
        tbl[3] = '{fid: 7, l2: 20, mode: 2, exp_size: 65536, exp_lines: 1024, pat: 2, hold: 0};
        tbl[4] = '{fid: 1, l2: 9,  mode: 3, exp_size: 512,   exp_lines: 8,    pat: 1, hold: 1};
        tbl[5] = '{fid: 2, l2: 6,  mode: 1, exp_size: 64,    exp_lines: 1,    pat: 0, hold: 0};

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_all_conns", DW'(all_conns_done), DW'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_fill(tbl[i].fid, tbl[i].l2, tbl[i].mode, tbl[i].exp_size,
                     tbl[i].exp_lines, tbl[i].pat, tbl[i].hold, 0, -1);

        // completion coinciding with clear_conns
        run_fill(4, 7, 1, 128, 2, 0, 0, 1, -1);
        chk("clear_same_cycle", DW'(conns_done), DW'(0));

        // reset in the middle of a transfer, then a clean fill
        run_fill(6, 9, 2, 512, 8, 0, 0, 0, 2);
        repeat (3) begin
            chk("no_resume_req", DW'(wr_req_val), DW'(0));
            chk("no_resume_done", DW'(done_val), DW'(0));
            @(negedge clk);
        end
        run_fill(8, 8, 1, 256, 4, 0, 0, 0, -1);
        chk("post_abort_conns", DW'(conns_done), DW'(1));

        cfg_num_conns = 16'd0;
        for (int i = 0; i < 10; i++) begin
            int l2 = $urandom_range(0, 11);
            int eff = (l2 < 6) ? 6 : (l2 > 16) ? 16 : l2;
            int sz = 1 << eff;
            run_fill(int'($urandom_range(0, 255)), l2, int'($urandom_range(0, 3)),
                     sz, sz / 64, 2, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/setup_buf_fill_engine.md
SETUP_BUF_FILL_ENGINE -- requirements
Module: setup_buf_fill_engine

Interface
REQ-001 Parameter DATA_W, default 512, SHALL set the write-data line width in bits (power of two, >= 64).
REQ-002 Parameter WORD_W, default 32, SHALL set the fill-pattern word width in bits (divides DATA_W).
REQ-003 Parameter FLOWID_W, default 8, SHALL set the flow ID width in bits.
REQ-004 Parameter MAX_PTR_W, default 16, SHALL set log2 of the largest buffer in bytes that can be filled.
REQ-005 Parameter CONN_W, default 16, SHALL set the connection counter width in bits.
REQ-006 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_val  in  1  fill command valid
- cmd_rdy  out  1  fill command accept
- cmd_flowid  in  FLOWID_W  flow to fill
- cmd_log2_size  in  5  log2 of buffer bytes
- cmd_mode  in  2  pattern: 0 ZERO, 1 LINE_IDX, 2 INCR, 3 reserved
- wr_req_val  out  1  buffer write request valid
- wr_req_rdy  in  1  buffer write request accept
- wr_req_flowid  out  FLOWID_W  request flow
- wr_req_offset  out  MAX_PTR_W  write offset, always 0
- wr_req_size  out  MAX_PTR_W+1  total bytes
- wr_data_val  out  1  data line valid
- wr_data_rdy  in  1  data line accept
- wr_data  out  DATA_W  data line
- wr_data_last  out  1  final line
- done_val  out  1  fill complete
- done_rdy  in  1  completion accept
- done_flowid  out  FLOWID_W  completed flow
- cfg_num_conns  in  CONN_W  expected connection count
- clear_conns  in  1  zero the connection counter
- conns_done  out  CONN_W  completed fills
- all_conns_done  out  1  conns_done == cfg_num_conns and cfg_num_conns != 0

Function
REQ-007 The module SHALL have four FSM states: IDLE, REQ, DATA, DONE.
REQ-008 cmd_rdy SHALL be 1 only in IDLE. When cmd_val & cmd_rdy, the module SHALL latch flowid, mode and effective size, and enter REQ.
REQ-009 Effective log2 size SHALL be clamped to the range [log2(DATA_W/8), MAX_PTR_W]. wr_req_size SHALL equal 1 << effective log2 size.
REQ-010 In REQ, wr_req_val SHALL be 1. On wr_req_rdy the module SHALL go to DATA with line counter = 0.
REQ-011 In DATA, wr_data_val SHALL be 1. Each wr_data_val & wr_data_rdy SHALL increment the line counter.
REQ-012 The number of lines SHALL be wr_req_size/(DATA_W/8).
REQ-013 wr_data_last SHALL be 1 on the line with counter == lines-1. Acceptance of that line SHALL move the FSM to DONE.
REQ-014 Data SHALL not change while wr_data_val=1 and wr_data_rdy=0.
REQ-015 Pattern for line n, word k (k=0 at LSBs), truncated to WORD_W:
- ZERO: 0
- LINE_IDX: n
- INCR: n*(DATA_W/WORD_W)+k
- mode 3: treated as ZERO
REQ-016 In DONE, done_val SHALL be 1 and done_flowid SHALL equal the latched flow. On done_rdy the FSM SHALL return to IDLE and conns_done SHALL increment.
REQ-017 conns_done SHALL saturate at all-ones.
REQ-018 clear_conns SHALL zero conns_done in the next cycle. If a done handshake happens in the same cycle, clear_conns SHALL take priority and conns_done SHALL become 0.
REQ-019 All outputs SHALL be registered-state derived, with no combinational path from any *_rdy to its own *_val.
REQ-020 Latency: cmd accept to wr_req_val SHALL be 1 cycle. wr_req accept to first wr_data_val SHALL be 1 cycle. Last-line accept to done_val SHALL be 1 cycle.

Reset
REQ-021 While rst=1, the FSM SHALL be in IDLE and all counters and latched fields SHALL be 0. This holds when rst is asserted mid-operation.
REQ-022 During reset, cmd_rdy SHALL be 1 and all other outputs SHALL be 0.
REQ-023 A transfer aborted by reset SHALL not be resumed or reported.

Verification
REQ-024 cmd(flowid=5, log2=8, mode=LINE_IDX) with DATA_W=512 -> wr_req size=256, offset=0; 4 lines, each word = line index 0..3; last on line 3; done_flowid=5; conns_done=1.
REQ-025 mode=INCR, log2=7, wr_data_rdy toggling 1/0 -> line0 words 0..15, line1 words 16..31; data stable during stalls; exactly 2 lines.
REQ-026 log2=2 -> 1 line, last=1; log2=20 with MAX_PTR_W=16 -> size 65536, 1024 lines.
REQ-027 cfg_num_conns=3, three fills complete -> all_conns_done=1 after the third done; clear_conns in the same cycle as a done -> conns_done=0.
REQ-028 rst asserted in DATA at line 2 -> outputs 0 and cmd_rdy=1 immediately; a new cmd afterwards completes normally with conns_done=1.
REQ-029 mode=3 and cmd_val held high while busy -> all-zero data; the second cmd is accepted only after the done handshake.
